uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 33 +++
 rtl/uart_tx_sched_arbiter.sv | 36 +++
 rtl/uart_tx_sched.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared states, UART register map and init-sequence helper for uart_tx_sched
package uart_tx_sched_pkg;
    typedef enum logic [2:0] {
        IDLE,
        INIT_SETUP,
        INIT_ACCESS,
        READY,
        POLL_SETUP,
        POLL_ACCESS,
        WR_SETUP,
        WR_ACCESS
    } state_t;
    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_DLL = 3'd0;
    localparam logic [2:0] REG_DLM = 3'd1;
    localparam logic [2:0] REG_FCR = 3'd2;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;
    localparam int LCR_DLAB = 7;
    localparam int LSR_THRE = 5;
    localparam logic [7:0] FCR_INIT = 8'h06;
    localparam logic [2:0] INIT_LAST = 3'd4;
    // {offset, data} of init write number step: LCR with DLAB set, DLL, DLM, LCR with DLAB clear, FCR
    function automatic logic [10:0] init_op(input logic [2:0] step, input logic [15:0] div, input logic [6:0] lcr);
        logic [7:0] lcr_d;
        lcr_d = {1'b0, lcr};
        lcr_d[LCR_DLAB] = step == 3'd0;
        return step == 3'd0 ? {REG_LCR, lcr_d} :
               step == 3'd1 ? {REG_DLL, div[7:0]} :
               step == 3'd2 ? {REG_DLM, div[15:8]} :
               step == 3'd3 ? {REG_LCR, lcr_d} : {REG_FCR, FCR_INIT};
    endfunction
endpackage

// File: rtl/uart_tx_sched_arbiter.sv
// uart_rr_arbiter: round-robin one-hot grant starting after the last granted index
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       hit
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] last;
    logic [IW-1:0] sel;
    logic found;
    // scan from farthest to nearest so the requester right after last wins
    always_comb begin
        sel = last;
        found = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[IW'((int'(last) + i) % NUM_REQ)]) begin
                sel = IW'((int'(last) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
    assign hit = en && found;
    assign grant = hit ? NUM_REQ'(1) << sel : '0;
    assign grant_idx = sel;
    // last-grant pointer; reset value makes requester 0 the first winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last <= IW'(NUM_REQ - 1);
        else if (hit) last <= sel;
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: APB master that configures a 16550-style UART and feeds it bytes from NUM_REQ requesters
// Optional packet lock: define UART_TX_SCHED_PKT_LOCK_EN to hold the grant on one requester until req_last_i.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int NUM_REQ = 4,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [15:0]               cfg_div_i,
    input  logic [7:0]                cfg_lcr_i,
    input  logic                      cfg_start_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*8-1:0]      req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic                      init_done_o,
    output logic                      err_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;
    state_t state;
    logic [2:0] step;
    logic [15:0] div_q;
    logic [6:0] lcr_q;
    logic [CW-1:0] credit;
    logic [NUM_REQ-1:0] arb_req;
    logic [IW-1:0] gnt_idx;
    logic hit, gnt_en, start_go, acc_done;
    logic [10:0] op_first, op_next;
    logic unused_ok;
    assign start_go = cfg_start_i && (state == IDLE || state == READY);
    assign acc_done = PSEL && PENABLE && PREADY;
    assign gnt_en = state == READY && credit != '0 && !cfg_start_i;
    assign op_first = init_op(3'd0, cfg_div_i, cfg_lcr_i[6:0]);
    assign op_next = init_op(step + 3'd1, div_q, lcr_q);
    assign unused_ok = ^{cfg_lcr_i[7], PRDATA[31:6], PRDATA[4:0], req_last_i};
`ifdef UART_TX_SCHED_PKT_LOCK_EN
    logic locked;
    logic [IW-1:0] lock_idx;
    assign arb_req = locked ? req_valid_i & (NUM_REQ'(1) << lock_idx) : req_valid_i;
    // packet lock: hold the winner until it hands over its last byte
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            locked <= 1'b0;
            lock_idx <= '0;
        end else if (start_go) begin
            locked <= 1'b0;
        end else if (hit) begin
            locked <= !req_last_i[gnt_idx];
            lock_idx <= gnt_idx;
        end
    end
`else
    assign arb_req = req_valid_i;
`endif
    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (CLK),
        .rst_n     (RSTN),
        .req       (arb_req),
        .en        (gnt_en),
        .grant     (req_ready_o),
        .grant_idx (gnt_idx),
        .hit       (hit)
    );
    // sequencer: init writes, LSR credit polls and THR byte writes over APB; PWDATA doubles as the latched byte
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
            step <= '0;
            div_q <= '0;
            lcr_q <= '0;
            credit <= '0;
            init_done_o <= 1'b0;
            err_o <= 1'b0;
            PSEL <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE <= 1'b0;
            PADDR <= '0;
            PWDATA <= '0;
        end else begin
            if (acc_done && PSLVERR) err_o <= 1'b1;
            if (start_go) begin
                state <= INIT_SETUP;
                step <= '0;
                div_q <= cfg_div_i;
                lcr_q <= cfg_lcr_i[6:0];
                credit <= '0;
                init_done_o <= 1'b0;
                PSEL <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE <= 1'b1;
                PADDR <= BASE_ADDR + APB_ADDR_WIDTH'(op_first[10:8]);
                PWDATA <= {24'b0, op_first[7:0]};
            end else begin
                case (state)
                    INIT_SETUP: begin
                        PENABLE <= 1'b1;
                        state <= INIT_ACCESS;
                    end
                    POLL_SETUP: begin
                        PENABLE <= 1'b1;
                        state <= POLL_ACCESS;
                    end
                    WR_SETUP: begin
                        PENABLE <= 1'b1;
                        state <= WR_ACCESS;
                    end
                    INIT_ACCESS: if (PREADY) begin
                        PENABLE <= 1'b0;
                        if (step == INIT_LAST) begin
                            PSEL <= 1'b0;
                            state <= READY;
                            init_done_o <= 1'b1;
                            credit <= '0;
                        end else begin
                            step <= step + 3'd1;
                            PADDR <= BASE_ADDR + APB_ADDR_WIDTH'(op_next[10:8]);
                            PWDATA <= {24'b0, op_next[7:0]};
                            state <= INIT_SETUP;
                        end
                    end
                    READY: if (hit) begin
                        credit <= credit - CW'(1);
                        state <= WR_SETUP;
                        PSEL <= 1'b1;
                        PWRITE <= 1'b1;
                        PADDR <= BASE_ADDR + APB_ADDR_WIDTH'(REG_THR);
                        PWDATA <= {24'b0, req_data_i[gnt_idx*8 +: 8]};
                    end else if (|req_valid_i && credit == '0) begin
                        state <= POLL_SETUP;
                        PSEL <= 1'b1;
                        PWRITE <= 1'b0;
                        PADDR <= BASE_ADDR + APB_ADDR_WIDTH'(REG_LSR);
                        PWDATA <= '0;
                    end
                    POLL_ACCESS: if (PREADY) begin
                        PSEL <= 1'b0;
                        PENABLE <= 1'b0;
                        state <= READY;
                        if (PRDATA[LSR_THRE]) credit <= CW'(TX_FIFO_DEPTH);
                    end
                    WR_ACCESS: if (PREADY) begin
                        PSEL <= 1'b0;
                        PENABLE <= 1'b0;
                        state <= READY;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench with APB slave model, requester model and THR byte scoreboard
module tb_uart_tx_sched;
    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic [15:0] cfg_div_i = '0;
    logic [7:0] cfg_lcr_i = '0;
    logic cfg_start_i = 1'b0;
    logic [3:0] req_valid_i, req_last_i, req_ready_o;
    logic [31:0] req_data_i;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic PWRITE, PSEL, PENABLE, init_done_o, err_o;
    logic PREADY = 1'b0;
    logic PSLVERR = 1'b0;
    typedef struct {
        logic w;
        logic [11:0] a;
        logic [31:0] d;
        int n;
    } tx_t;
    tx_t txlog[$];
    logic [7:0] byte_q[$];
    int grant_log[$];
    logic [31:0] lsr_q[$];
    int len[4] = '{0, 0, 0, 0};
    int sent[4] = '{0, 0, 0, 0};
    int thr_wait = 0;
    int acc_cnt = 0;
    int wait_now = 0;
    int sel_cycles = 0;
    logic thr_err = 1'b0;
    logic [3:0] taken = '0;
    int errors = 0;
    int checks = 0;

    uart_tx_sched dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .cfg_div_i   (cfg_div_i),
        .cfg_lcr_i   (cfg_lcr_i),
        .cfg_start_i (cfg_start_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .init_done_o (init_done_o),
        .err_o       (err_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // requester i offers bytes 16*i+n until len[i] bytes are accepted; last marks the final byte
    always_comb begin
        req_valid_i = '0;
        req_last_i = '0;
        req_data_i = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid_i[i] = sent[i] < len[i];
            req_last_i[i] = sent[i] == len[i] - 1;
            req_data_i[i*8 +: 8] = 8'(16 * i + sent[i]);
        end
    end

    // accepted bytes advance the requester just after the edge that took them
    always @(posedge CLK) begin
        #1;
        for (int i = 0; i < 4; i++) if (taken[i]) sent[i]++;
    end

    // APB slave and grant monitor, evaluated mid-cycle for the coming edge
    always @(negedge CLK) begin
        if (PSEL) sel_cycles++;
        if (PSEL && PENABLE) begin
            wait_now = (PWRITE && init_done_o) ? thr_wait : 0;
            if (acc_cnt >= wait_now) begin
                PREADY = 1'b1;
                PSLVERR = PWRITE && init_done_o && thr_err;
                PRDATA = PWRITE ? 32'h0 : (lsr_q.size() != 0 ? lsr_q.pop_front() : 32'h60);
                txlog.push_back('{PWRITE, PADDR, PWDATA, acc_cnt + 1});
                if (PWRITE && PADDR == 12'h0 && init_done_o) begin
                    if (byte_q.size() == 0) chk("thr_unexpected", {32'h0, PWDATA}, 64'hFFFF);
                    else chk("thr_data", {32'h0, PWDATA}, {56'h0, byte_q.pop_front()});
                end
            end else begin
                PREADY = 1'b0;
                PSLVERR = 1'b0;
            end
            acc_cnt++;
        end else begin
            PREADY = 1'b0;
            PSLVERR = 1'b0;
            PRDATA = '0;
            acc_cnt = 0;
        end
        taken = req_ready_o;
        for (int i = 0; i < 4; i++) begin
            if (taken[i]) begin
                chk("ready_legal", {61'h0, init_done_o, req_valid_i[i], $onehot(req_ready_o)}, 64'h7);
                byte_q.push_back(req_data_i[i*8 +: 8]);
                grant_log.push_back(i);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic start(input logic [15:0] div, input logic [7:0] lcr);
        txlog.delete();
        cfg_div_i = div;
        cfg_lcr_i = lcr;
        cfg_start_i = 1'b1;
        cyc(1);
        cfg_start_i = 1'b0;
    endtask

    task automatic wait_init();
        for (int k = 0; k < 200 && init_done_o !== 1'b1; k++) cyc(1);
        chk("init_done", {63'h0, init_done_o}, 64'h1);
    endtask

    task automatic wait_log(input int n, input string tag);
        for (int k = 0; k < 3000 && txlog.size() < n; k++) cyc(1);
        chk(tag, txlog.size(), n);
    endtask

    task automatic reset_init();
        RSTN = 1'b0;
        len = '{0, 0, 0, 0};
        sent = '{0, 0, 0, 0};
        byte_q.delete();
        grant_log.delete();
        lsr_q.delete();
        thr_wait = 0;
        thr_err = 1'b0;
        cyc(2);
        RSTN = 1'b1;
        cyc(1);
        start(16'h0145, 8'h03);
        wait_init();
        txlog.delete();
    endtask

    initial begin
        int nreads;
        int fw;
        logic [11:0] iaddr[5];
        logic [31:0] idata[5];
        iaddr = '{12'h3, 12'h0, 12'h1, 12'h3, 12'h2};
        idata = '{32'h83, 32'h45, 32'h01, 32'h03, 32'h06};
        cyc(3);
        chk("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready_o, init_done_o, err_o}, 64'h0);
        RSTN = 1'b1;
        sel_cycles = 0;
        cyc(20);
        chk("no_apb_before_start", sel_cycles, 0);
        start(16'h0145, 8'h03);
        wait_init();
        chk("init_count", txlog.size(), 5);
        for (int i = 0; i < 5 && i < txlog.size(); i++)
            chk("init_write", {txlog[i].w, txlog[i].a, txlog[i].d}, {1'b1, iaddr[i], idata[i]});
        txlog.delete();
        len[0] = 20;
        wait_log(22, "burst20_count");
        nreads = 0;
        foreach (txlog[i]) if (!txlog[i].w) nreads++;
        chk("burst20_lsr_reads", nreads, 2);
        if (txlog.size() >= 18) begin
            chk("burst20_first_lsr", {txlog[0].w, txlog[0].a}, {1'b0, 12'h5});
            chk("burst20_second_lsr", {txlog[17].w, txlog[17].a}, {1'b0, 12'h5});
        end
        chk("burst20_drained", {sent[0], byte_q.size()}, {32'd20, 32'd0});
        cyc(2);
        start(16'h0145, 8'h03);
        chk("restart_clears_done", {63'h0, init_done_o}, 64'h0);
        wait_init();
        chk("restart_init_count", txlog.size(), 5);
        reset_init();
        len = '{3, 3, 3, 3};
        for (int k = 0; k < 3000 && (grant_log.size() < 12 || byte_q.size() != 0); k++) cyc(1);
        chk("rr_grant_count", grant_log.size(), 12);
        foreach (grant_log[i]) chk("rr_order", grant_log[i], i % 4);
        reset_init();
        lsr_q = {32'h0, 32'h0, 32'h0, 32'h60};
        len[0] = 2;
        wait_log(6, "poll_count");
        fw = -1;
        nreads = 0;
        foreach (txlog[i]) begin
            if (txlog[i].w && fw < 0) fw = i;
            if (!txlog[i].w && txlog[i].a == 12'h5) nreads++;
        end
        chk("poll_reads_before_thr", fw, 4);
        chk("poll_lsr_reads", nreads, 4);
        reset_init();
        thr_wait = 3;
        thr_err = 1'b1;
        len[0] = 1;
        wait_log(2, "slverr_count");
        if (txlog.size() >= 2) chk("thr_access_len", txlog[1].n, 4);
        chk("err_set", {63'h0, err_o}, 64'h1);
        thr_err = 1'b0;
        len[0] = 2;
        wait_log(3, "sticky_count");
        chk("err_sticky", {63'h0, err_o}, 64'h1);
        thr_wait = 1000;
        len[0] = 3;
        for (int k = 0; k < 100 && !(PSEL && PENABLE && PWRITE); k++) cyc(1);
        chk("wr_access_reached", {63'h0, PSEL && PENABLE && PWRITE}, 64'h1);
        RSTN = 1'b0;
        #1;
        chk("async_reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready_o, init_done_o, err_o}, 64'h0);
`ifdef UART_TX_SCHED_PKT_LOCK_EN
        reset_init();
        len[1] = 3;
        for (int k = 0; k < 200 && grant_log.size() < 1; k++) cyc(1);
        len[0] = 1;
        for (int k = 0; k < 400 && grant_log.size() < 4; k++) cyc(1);
        chk("lock_grant_count", grant_log.size(), 4);
        if (grant_log.size() >= 4)
            chk("lock_order", {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]}, 16'h1110);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
